// File: rtl/fft_power_peak_if.sv
`default_nettype none
// ============================================================================
// Module      : fft_power_peak_if
// Description : Input bin stream and output power stream for fft_power_peak.
// Revision    : 1.0 - initial release
// ============================================================================
interface fft_power_peak_if #(
    parameter int DW = 16
);
    logic              in_valid;
    logic [2*DW-1:0]   in_data;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [2*DW-1:0]   out_power;
    logic [3:0]        out_index;
    logic              out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  out_valid, out_power, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output out_valid, out_power, out_index, out_last
    );
endinterface
`default_nettype wire

// File: rtl/fft_power_peak.sv
`default_nettype none
// ============================================================================
// Module      : fft_power_peak
// Description : Captures a 16-bin FFT frame, converts bins to power, tracks the
//               peak and streams powers out in natural bin order.
// Revision    : 1.0 - initial release
// ============================================================================
module fft_power_peak #(
    parameter int DW      = 16,
    parameter bit BIT_REV = 1'b1
) (
    input  wire logic            clk,
    input  wire logic            reset,
    fft_power_peak_if.slave      bus,
    output logic                 peak_valid,
    output logic [3:0]           peak_index,
    output logic [2*DW-1:0]      peak_power,
    output logic                 frame_err,
    output logic                 frame_drop,
    output logic                 busy
);
    localparam logic [1:0] c_COLLECT = 2'd0;
    localparam logic [1:0] c_FLUSH   = 2'd1;
    localparam logic [1:0] c_DRAIN   = 2'd2;
    localparam logic [1:0] c_DROP    = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [3:0]          r_wr_cnt;
    logic [3:0]          r_rd_cnt;
    logic [2*DW-1:0]     r_ram [16];
    logic [2*DW-1:0]     r_peak_power;
    logic [3:0]          r_peak_index;
    logic                r_frame_err;
    logic                r_frame_drop;
    logic                r_drop_pend;
    logic                r_drop_ended;

    logic signed [2*DW-1:0] w_re_ext;
    logic signed [2*DW-1:0] w_im_ext;
    logic [2*DW-1:0]     w_re_sq;
    logic [2*DW-1:0]     w_im_sq;
    logic [2*DW-1:0]     w_power;
    logic [3:0]          w_addr;
    logic                w_wr;
    logic                w_word_last;
    logic                w_xfer;
    logic                w_drop_any;
    logic                w_drop_done;
    logic                w_draining;

    // Each square is at most 2^(2*DW-2), so the sum always fits in 2*DW bits.
    assign w_re_ext    = {{DW{bus.in_data[2*DW-1]}}, bus.in_data[2*DW-1:DW]};
    assign w_im_ext    = {{DW{bus.in_data[DW-1]}},   bus.in_data[DW-1:0]};
    assign w_re_sq     = w_re_ext * w_re_ext;
    assign w_im_sq     = w_im_ext * w_im_ext;
    assign w_power     = w_re_sq + w_im_sq;

    assign w_wr        = bus.in_valid && (r_state == c_COLLECT);
    assign w_word_last = (r_wr_cnt == 4'd15);
    assign w_xfer      = (r_state == c_DRAIN) && bus.out_ready;
    // A word arriving in the final DRAIN cycle still counts toward the drop.
    assign w_drop_any  = r_drop_pend || bus.in_valid;
    assign w_drop_done = r_drop_ended || (bus.in_valid && bus.in_last);

    generate
        if (BIT_REV) begin : g_bitrev
            assign w_addr = {r_wr_cnt[0], r_wr_cnt[1], r_wr_cnt[2], r_wr_cnt[3]};
        end else begin : g_natural
            assign w_addr = r_wr_cnt;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_COLLECT: if (w_wr && w_word_last && bus.in_last) w_state_next = c_FLUSH;
            c_FLUSH:   w_state_next = c_DRAIN;
            c_DRAIN: begin
                if (w_xfer && (r_rd_cnt == 4'd15)) begin
                    w_state_next = (w_drop_any && !w_drop_done) ? c_DROP : c_COLLECT;
                end
            end
            c_DROP:    if (bus.in_valid && bus.in_last) w_state_next = c_COLLECT;
            default:   w_state_next = c_COLLECT;
        endcase
    end

    always_comb begin
        w_draining    = (r_state == c_DRAIN);
        bus.out_valid = w_draining;
        bus.out_power = w_draining ? r_ram[r_rd_cnt] : '0;
        bus.out_index = w_draining ? r_rd_cnt : 4'd0;
        bus.out_last  = w_draining && (r_rd_cnt == 4'd15);
        peak_valid    = (r_state == c_FLUSH);
        busy          = (r_state != c_COLLECT);
    end

    always_ff @(posedge clk) begin
        if (w_wr && !reset) begin
            r_ram[w_addr] <= w_power;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_cnt     <= 4'd0;
            r_rd_cnt     <= 4'd0;
            r_peak_power <= '0;
            r_peak_index <= 4'd0;
            r_frame_err  <= 1'b0;
            r_frame_drop <= 1'b0;
            r_drop_pend  <= 1'b0;
            r_drop_ended <= 1'b0;
        end else begin
            r_frame_err  <= 1'b0;
            r_frame_drop <= 1'b0;

            if (w_wr) begin
                // Ties resolve to the lowest natural bin regardless of arrival order.
                if ((r_wr_cnt == 4'd0) || (w_power > r_peak_power) ||
                    ((w_power == r_peak_power) && (w_addr < r_peak_index))) begin
                    r_peak_power <= w_power;
                    r_peak_index <= w_addr;
                end
                if (w_word_last || bus.in_last) begin
                    r_wr_cnt    <= 4'd0;
                    r_frame_err <= (w_word_last != bus.in_last);
                end else begin
                    r_wr_cnt <= r_wr_cnt + 4'd1;
                end
            end

            if (r_state == c_FLUSH) begin
                r_rd_cnt <= 4'd0;
            end else if (w_xfer) begin
                r_rd_cnt <= r_rd_cnt + 4'd1;
            end

            if (r_state == c_COLLECT) begin
                r_drop_pend  <= 1'b0;
                r_drop_ended <= 1'b0;
            end else if (((r_state == c_FLUSH) || (r_state == c_DRAIN)) && bus.in_valid) begin
                if (!r_drop_pend) begin
                    r_frame_drop <= 1'b1;
                end
                r_drop_pend <= 1'b1;
                if (bus.in_last) begin
                    r_drop_ended <= 1'b1;
                end
            end
        end
    end

    assign peak_index = r_peak_index;
    assign peak_power = r_peak_power;
    assign frame_err  = r_frame_err;
    assign frame_drop = r_frame_drop;
endmodule
`default_nettype wire

// File: doc/fft_power_peak.md
# fft_power_peak

Downstream consumer of the 16-point serial FFT block. Captures one 16-word output frame, converts each complex bin to power (re² + im²) and optionally undoes bit-reversed bin ordering. Tracks the peak bin, then streams the 16 powers in natural bin order over a valid/ready interface to the spectrum post-processing logic.

## Interface
- DW, 16: signed component width; input word is {re[DW-1:0], im[DW-1:0]}, real in the upper half.
- BIT_REV, 1: 1 means arrival position k carries natural bin bitrev4(k); 0 means arrival order equals bin order.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  input word valid; connected to FFT data_out_valid.
- in_data  in  2*DW  complex bin {re, im}, two's complement.
- in_last  in  1  frame end; connected to FFT fft_done, coincident with the 16th in_valid.
- out_valid  out  1  out_power/out_index valid.
- out_ready  in  1  downstream accepts the current word.
- out_power  out  2*DW  unsigned re² + im².
- out_index  out  4  natural bin index of out_power.
- out_last  out  1  high with bin 15.
- peak_valid  out  1  1-cycle pulse; peak_index and peak_power valid.
- peak_index  out  4  bin with the maximum power.
- peak_power  out  2*DW  maximum power.
- frame_err  out  1  1-cycle pulse: in_last is not on the 16th word.
- frame_drop  out  1  1-cycle pulse: frame discarded because DRAIN is busy.
- busy  out  1  high in any state other than COLLECT.

## Operation
- States: COLLECT, FLUSH, DRAIN, DROP.
- COLLECT:
  - wr_cnt counts accepted words 0..15.
  - Each in_valid word is squared and summed into a 2*DW-bit power with no overflow. The maximum is 2^(2*DW-1), at re = im = -2^(DW-1).
  - The power is written to power_ram[addr], where addr = BIT_REV ? bitrev4(wr_cnt) : wr_cnt.
- Peak update:
  - Runs on each write.
  - Replace the running peak if power > peak_power, or if power == peak_power and addr < peak_index.
  - Ties therefore go to the lowest natural index.
  - The running peak clears at the first word of each frame.
- Word 16 with in_last=1 → FLUSH.
- Word 16 with in_last=0 → pulse frame_err, discard the frame, stay in COLLECT, wr_cnt→0.
- in_last=1 on words 1..15 → pulse frame_err, discard the frame, wr_cnt→0.
- FLUSH (1 cycle):
  - The last RAM write completes.
  - peak_valid pulses with the final peak.
  - Go to DRAIN with rd_cnt=0.
- DRAIN:
  - out_valid=1, out_power=power_ram[rd_cnt], out_index=rd_cnt, out_last=(rd_cnt==15).
  - Outputs stay stable while out_ready=0.
  - A transfer occurs on out_valid && out_ready: rd_cnt+1.
  - A transfer with out_last → COLLECT, out_valid=0.
- in_valid while in FLUSH/DRAIN:
  - Pulse frame_drop on the first such word, go to DROP after DRAIN completes.
  - Otherwise ignore the word.
  - DROP consumes the remainder of the overlapping frame until the word with in_last, then → COLLECT.
  - If that frame already ended during DRAIN, go straight to COLLECT.
- The RAM is 16 × 2*DW registers or inferred RAM. Its content is don't-care after reset.

## Timing
- Reset values: out_valid=0, out_last=0, out_power=0, out_index=0, peak_valid=0, peak_index=0, peak_power=0, frame_err=0, frame_drop=0, busy=0. State=COLLECT, wr_cnt=0, rd_cnt=0.
- Reset mid-frame or mid-drain abandons all data. The next in_valid is word 0 of a new frame.
- Word 16 accepted at edge T:
  - T+1: FLUSH, peak_valid=1.
  - T+2: out_valid=1 for bin 0.
- With out_ready held 1, bins 0..15 appear on 16 consecutive cycles, T+2..T+17. COLLECT is re-entered at T+18.
- Minimum frame-to-frame spacing without a drop: 18 cycles from last word to next first word. The upstream FFT spacing exceeds this.
- out_ready must not be sampled combinationally to out_valid. out_valid is registered.
- frame_err/frame_drop assert the cycle after the offending word.

## Test plan
- BIT_REV=1, frame of all-zero words except arrival position 1 = {re=3, im=4} → output bin 8 power=25, all other bins 0; peak_index=8, peak_power=25; out_last on bin 15.
- BIT_REV=0, arrival k carries {re=k, im=0} → out_power[k]=k² in order 0..15; peak_index=15, peak_power=225; peak_valid exactly 1 cycle before the first out_valid.
- Word {re=-32768, im=-32768} at bin 5, all others zero → power=0x80000000, peak_index=5; equal powers at bins 2 and 9 (no larger value) → peak_index=2.
- out_ready toggled 1,0,0,1 during DRAIN → no bin skipped or repeated; out_power/out_index held stable while out_ready=0; 16 transfers total.
- in_last asserted on word 10 → frame_err pulse, no out_valid; the following clean 16-word frame drains normally.
- out_ready held 0 while a second frame arrives → frame_drop pulse, first frame's data unaltered on release, second frame produces no output; reset asserted mid-DRAIN → all outputs at reset values next cycle.
